ula_arbiter: RTL
================

Name: ula_arbiter

Overview:
Shares one combinational ULA (8-bit operands; add/sub/mul; 16-bit result; zero/sign flags) between two requesters.
- Round-robin arbitration; one transaction in flight.
- Drives ULA operands and selectors from registers, captures result and flags, returns a tagged response with valid/ready backpressure.
- Sits between the ULA instance and the two client datapaths.

Parameters:
NUM_OPS, 3, number of legal selector codes (0=add, 1=sub, 2=mul); codes >= NUM_OPS are illegal.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous reset, active-low
req_valid  input  2  per-requester request valid (bit i = requester i)
req_ready  output  2  per-requester accept; at most one bit high
req_a0  input  8  operand a, requester 0
req_b0  input  8  operand b, requester 0
req_op0  input  4  selector code, requester 0
req_a1  input  8  operand a, requester 1
req_b1  input  8  operand b, requester 1
req_op1  input  4  selector code, requester 1
ula_a  output  8  registered operand a to ULA
ula_b  output  8  registered operand b to ULA
ula_sel  output  4  registered selectors to ULA
ula_result  input  16  ULA result
ula_zero  input  1  ULA zero flag
ula_sign  input  1  ULA sign flag
rsp_valid  output  1  response valid
rsp_ready  input  1  response accept
rsp_id  output  1  requester that owns the response
rsp_result  output  16  captured result
rsp_zero  output  1  captured zero flag
rsp_sign  output  1  captured sign flag
rsp_err  output  1  illegal op code; result and flags forced 0
busy  output  1  high in ISSUE or RESP

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, last_grant=1 (requester 0 wins first). ula_a, ula_b, ula_sel, rsp_* all 0. req_ready=0, busy=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE, grant rule:
  - One valid: grant it.
  - Both valid: grant ~last_grant.
  - req_ready[g] is combinational and asserted only in IDLE for the granted g.
- IDLE, on handshake (req_valid[g] & req_ready[g]):
  - Latch ula_a/ula_b/ula_sel from requester g.
  - Latch id=g; update last_grant=g.
  - Go to ISSUE.
- IDLE with no valid: stay; outputs hold.
- ISSUE (exactly 1 cycle): ULA inputs are stable. At the clock edge:
  - Capture ula_result, ula_zero, ula_sign into rsp_*; set rsp_id=id.
  - rsp_err = (ula_sel >= NUM_OPS). If err, rsp_result=0, rsp_zero=0, rsp_sign=0.
  - rsp_valid=1; go to RESP.
- RESP: hold all rsp_* stable while rsp_valid & !rsp_ready.
  - On rsp_ready: rsp_valid=0 next cycle; go to IDLE.
  - No new request is accepted in the RESP-exit cycle; the earliest next accept is the following cycle.
- Latency: request accept at cycle N → rsp_valid at N+2.
  - Minimum throughput: one transaction per 3 cycles with rsp_ready held high.
- ula_a/ula_b/ula_sel hold the last issued values until the next accept; they are not cleared after a response.
- Arithmetic: the block performs no arithmetic. ULA outputs are captured verbatim (16-bit, no truncation).
- Requests whose valid drops before a grant are discarded silently. Requesters hold operands stable while valid & !ready.
- Fairness: under continuous dual requests, grants strictly alternate 0,1,0,1.
- rst_n low in any state (mid-ISSUE or mid-RESP) aborts the transaction next edge:
  - The pending response is lost; rsp_valid=0, state=IDLE, last_grant=1.

Test Plan:
- Reset, then requester 0 sends a=8'd200, b=8'd100, op=0 → req_ready=2'b01 at cycle 0. Two cycles later: rsp_valid=1, rsp_id=0, rsp_result=16'd300, zero=0, sign=0, err=0.
- Both valid continuously: requester 0 (a=3, b=5, op=1), requester 1 (a=12, b=12, op=2), rsp_ready=1 → grant order 0,1,0,1.
  - Responses alternate id 0/1 with results matching the ULA sub/mul outputs for those operands (mul: 16'd144).
  - One accept every 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_* stable for all 5 cycles, req_ready=0 throughout. Response consumed on the first cycle rsp_ready=1.
- Illegal op: requester 1 sends op=4'd7 → rsp_err=1, rsp_result=0, rsp_zero=0, rsp_sign=0, rsp_id=1. Next transaction is unaffected.
- Flags: a=8'd5, b=8'd5, op=1 → rsp_zero=1. A transaction whose ULA sign flag is 1 → rsp_sign=1.
- rst_n pulsed low during RESP → rsp_valid=0 next cycle, busy=0. Then, with both valid, requester 0 is granted first.

Source files
------------

// File: rtl/ula_arbiter_if.sv
// Bundle of the request, ULA and response signals around ula_arbiter.
// slave = arbiter view; master = client/ULA/environment view.
interface ula_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_a0;
    logic [7:0]  req_b0;
    logic [3:0]  req_op0;
    logic [7:0]  req_a1;
    logic [7:0]  req_b1;
    logic [3:0]  req_op1;
    logic [7:0]  ula_a;
    logic [7:0]  ula_b;
    logic [3:0]  ula_sel;
    logic [15:0] ula_result;
    logic        ula_zero;
    logic        ula_sign;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_sign;
    logic        rsp_err;
    logic        busy;

    modport slave (
        input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1,
        input  ula_result, ula_zero, ula_sign, rsp_ready,
        output req_ready, ula_a, ula_b, ula_sel,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_sign, rsp_err, busy
    );

    modport master (
        output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1,
        output ula_result, ula_zero, ula_sign, rsp_ready,
        input  req_ready, ula_a, ula_b, ula_sel,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_sign, rsp_err, busy
    );
endinterface

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one combinational ULA between two requesters,
// one transaction in flight, tagged response with valid/ready backpressure.
module ula_arbiter #(
    parameter int unsigned NUM_OPS = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    ula_arbiter_if.slave  bus
);

    localparam logic [3:0] NUM_OPS_SEL = 4'(NUM_OPS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        id_q, id_d;
    logic [7:0]  ula_a_q, ula_a_d;
    logic [7:0]  ula_b_q, ula_b_d;
    logic [3:0]  ula_sel_q, ula_sel_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [15:0] rsp_result_q, rsp_result_d;
    logic        rsp_zero_q, rsp_zero_d;
    logic        rsp_sign_q, rsp_sign_d;
    logic        rsp_err_q, rsp_err_d;

    logic        any_valid;
    logic        grant;
    logic [1:0]  req_ready_c;
    logic        handshake;
    logic        sel_illegal;

    // Requester 1 wins alone or on a tie when requester 0 was granted last.
    assign any_valid   = |bus.req_valid;
    assign grant       = (&bus.req_valid) ? ~last_grant_q : bus.req_valid[1];
    assign handshake   = |(bus.req_valid & req_ready_c);
    assign sel_illegal = (ula_sel_q >= NUM_OPS_SEL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            ula_a_q      <= '0;
            ula_b_q      <= '0;
            ula_sel_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_sign_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            ula_a_q      <= ula_a_d;
            ula_b_q      <= ula_b_d;
            ula_sel_q    <= ula_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_sign_q   <= rsp_sign_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        ula_a_d      = ula_a_q;
        ula_b_d      = ula_b_q;
        ula_sel_d    = ula_sel_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_sign_d   = rsp_sign_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    ula_a_d      = grant ? bus.req_a1  : bus.req_a0;
                    ula_b_d      = grant ? bus.req_b1  : bus.req_b0;
                    ula_sel_d    = grant ? bus.req_op1 : bus.req_op0;
                    id_d         = grant;
                    last_grant_d = grant;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                rsp_valid_d  = 1'b1;
                rsp_id_d     = id_q;
                rsp_err_d    = sel_illegal;
                rsp_result_d = sel_illegal ? '0   : bus.ula_result;
                rsp_zero_d   = sel_illegal ? 1'b0 : bus.ula_zero;
                rsp_sign_d   = sel_illegal ? 1'b0 : bus.ula_sign;
                state_d      = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_c = '0;
        if (state_q == IDLE && any_valid) begin
            req_ready_c[grant] = 1'b1;
        end
        bus.req_ready  = req_ready_c;
        bus.busy       = (state_q == ISSUE) || (state_q == RESP);
        bus.ula_a      = ula_a_q;
        bus.ula_b      = ula_b_q;
        bus.ula_sel    = ula_sel_q;
        bus.rsp_valid  = rsp_valid_q;
        bus.rsp_id     = rsp_id_q;
        bus.rsp_result = rsp_result_q;
        bus.rsp_zero   = rsp_zero_q;
        bus.rsp_sign   = rsp_sign_q;
        bus.rsp_err    = rsp_err_q;
    end

endmodule
